// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Multiply, and divide by a non-zero divisor, take the iterative path.
  function automatic logic needs_iter(input logic [2:0] op, input logic b_nonzero);
    return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
module mul_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] lo_next_c,
  output logic [WIDTH-1:0] hi_next_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] divisor;
  logic             div_mode;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;

  // hi is the running partial product / remainder, lo the multiplier / quotient.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : (WIDTH+1)'(0));
    div_shift = {hi, lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, divisor};
    hi_next_c = hi;
    lo_next_c = lo;
    if (div_mode) begin
      if (!div_trial[WIDTH]) begin
        hi_next_c = div_trial[WIDTH-1:0];
        lo_next_c = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next_c = div_shift[WIDTH-1:0];
        lo_next_c = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_next_c, lo_next_c} = {mul_sum, lo[WIDTH-1:1]};
    end
  end

  assign last_c = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      divisor  <= '0;
      div_mode <= 1'b0;
      count    <= '0;
    end else if (start) begin
      hi       <= '0;
      lo       <= a;
      divisor  <= b;
      div_mode <= is_div;
      count    <= '0;
    end else if (step) begin
      hi    <= hi_next_c;
      lo    <= lo_next_c;
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready handshake, single-cycle logic/arith ops, iterative MUL/DIV.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Operation,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] OutputHi,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             DivByZero,
  output logic             OutValid,
  input  logic             OutReady
);

  logic [1:0]       state, state_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [WIDTH-1:0] out_nxt, hi_nxt;
  logic             zero_nxt, carry_nxt, ovf_nxt, dbz_nxt;
  logic             in_ready_nxt, out_valid_nxt;
  logic             start_c;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             iter_last_c;
  logic [WIDTH-1:0] iter_lo_c, iter_hi_c;

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .start     (start_c),
    .is_div    (Operation == OP_DIV),
    .step      (state == ST_CALC),
    .a         (A),
    .b         (B),
    .last_c    (iter_last_c),
    .lo_next_c (iter_lo_c),
    .hi_next_c (iter_hi_c)
  );

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};

  // Next-state and next-output logic; outputs hold unless a result is produced.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    out_nxt   = Output;
    hi_nxt    = OutputHi;
    zero_nxt  = Zero;
    carry_nxt = Carry;
    ovf_nxt   = Overflow;
    dbz_nxt   = DivByZero;
    start_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (InValid) begin
          op_nxt = Operation;
          if (needs_iter(Operation, B != '0)) begin
            state_nxt = ST_CALC;
            start_c   = 1'b1;
          end else begin
            state_nxt = ST_DONE;
            hi_nxt    = '0;
            carry_nxt = 1'b0;
            ovf_nxt   = 1'b0;
            dbz_nxt   = 1'b0;
            case (Operation)
              OP_NOT: out_nxt = ~A;
              OP_AND: out_nxt = A & B;
              OP_OR:  out_nxt = A | B;
              OP_XOR: out_nxt = A ^ B;
              OP_ADD: begin
                out_nxt   = sum_ext[WIDTH-1:0];
                carry_nxt = sum_ext[WIDTH];
                ovf_nxt   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
              end
              OP_SUB: begin
                out_nxt   = diff_ext[WIDTH-1:0];
                carry_nxt = diff_ext[WIDTH];
                ovf_nxt   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
              end
              default: begin
                out_nxt = '1;
                hi_nxt  = A;
                dbz_nxt = 1'b1;
              end
            endcase
            zero_nxt = (out_nxt == '0);
          end
        end
      end
      ST_CALC: begin
        if (iter_last_c) begin
          state_nxt = ST_DONE;
          out_nxt   = iter_lo_c;
          hi_nxt    = iter_hi_c;
          zero_nxt  = (iter_lo_c == '0);
          carry_nxt = 1'b0;
          ovf_nxt   = (op_q == OP_MUL) && (iter_hi_c != '0);
          dbz_nxt   = 1'b0;
        end
      end
      ST_DONE: begin
        if (OutReady) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    in_ready_nxt  = (state_nxt == ST_IDLE);
    out_valid_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      Output    <= '0;
      OutputHi  <= '0;
      Zero      <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      DivByZero <= 1'b0;
      InReady   <= 1'b1;
      OutValid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      Output    <= out_nxt;
      OutputHi  <= hi_nxt;
      Zero      <= zero_nxt;
      Carry     <= carry_nxt;
      Overflow  <= ovf_nxt;
      DivByZero <= dbz_nxt;
      InReady   <= in_ready_nxt;
      OutValid  <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed + random bench for seq_alu with an expected-result scoreboard.
module tb_seq_alu;

  localparam int unsigned W = 32;
  localparam logic [2:0] T_NOT = 3'b000, T_AND = 3'b001, T_OR  = 3'b010, T_ADD = 3'b011;
  localparam logic [2:0] T_SUB = 3'b100, T_MUL = 3'b101, T_DIV = 3'b110, T_XOR = 3'b111;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         Clock, Reset_n, InValid, OutReady;
  logic [W-1:0] A, B;
  logic [2:0]   Operation;
  logic         InReady, Zero, Carry, Overflow, DivByZero, OutValid;
  logic [W-1:0] Output, OutputHi;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .InValid   (InValid),
    .InReady   (InReady),
    .Output    (Output),
    .OutputHi  (OutputHi),
    .Zero      (Zero),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .DivByZero (DivByZero),
    .OutValid  (OutValid),
    .OutReady  (OutReady)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model built from wide integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned p;
    longint sr;
    e = '{out: '0, hi: '0, zero: 1'b0, carry: 1'b0, ovf: 1'b0, dbz: 1'b0, lat: 1};
    case (op)
      T_NOT: e.out = ~a;
      T_AND: e.out = a & b;
      T_OR:  e.out = a | b;
      T_XOR: e.out = a ^ b;
      T_ADD: begin
        p = longint'(a) + longint'(b);
        e.out = p[W-1:0];
        e.carry = (p > 64'h0000_0000_FFFF_FFFF);
        sr = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      T_SUB: begin
        e.out = a - b;
        e.carry = (a < b);
        sr = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      T_MUL: begin
        p = longint'(a) * longint'(b);
        e.out = p[31:0];
        e.hi = p[63:32];
        e.ovf = (e.hi != 0);
        e.lat = W + 1;
      end
      default: begin
        if (b == 0) begin
          e.out = '1;
          e.hi = a;
          e.dbz = 1'b1;
        end else begin
          e.out = a / b;
          e.hi = a % b;
          e.lat = W + 1;
        end
      end
    endcase
    e.zero = (e.out == 0);
    return e;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_inready"}, InReady, 1);
    chk({tag, "_outvalid"}, OutValid, 0);
    chk({tag, "_out"}, Output, 0);
    chk({tag, "_outhi"}, OutputHi, 0);
    chk({tag, "_flags"}, {Zero, Carry, Overflow, DivByZero}, 0);
  endtask

  task automatic check_result(input string tag, input exp_t e);
    chk({tag, "_out"}, Output, e.out);
    chk({tag, "_outhi"}, OutputHi, e.hi);
    chk({tag, "_zero"}, Zero, e.zero);
    chk({tag, "_carry"}, Carry, e.carry);
    chk({tag, "_ovf"}, Overflow, e.ovf);
    chk({tag, "_dbz"}, DivByZero, e.dbz);
  endtask

  // Issue one op, wait for OutValid, compare, optionally stall in DONE, then release.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op, a, b));
    A = a; B = b; Operation = op; InValid = 1'b1; OutReady = 1'b0;
    @(posedge Clock); #1;
    InValid = 1'b0; A = $urandom; B = $urandom; Operation = 3'($urandom);
    lat = 1;
    while (OutValid !== 1'b1 && lat < 100) begin
      chk({tag, "_busy_inready"}, InReady, 0);
      @(posedge Clock); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.lat);
    check_result(tag, e);
    for (int h = 0; h < hold; h++) begin
      A = $urandom; B = $urandom; Operation = 3'($urandom); InValid = 1'b1;
      @(posedge Clock); #1;
      check_result({tag, "_hold"}, e);
      chk({tag, "_hold_inready"}, InReady, 0);
      chk({tag, "_hold_outvalid"}, OutValid, 1);
    end
    InValid = 1'b0; OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    chk({tag, "_rel_outvalid"}, OutValid, 0);
    chk({tag, "_rel_inready"}, InReady, 1);
  endtask

  initial begin
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    A = '0; B = '0; Operation = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_reset("reset");
    Reset_n = 1'b1;

    run_op("add_wrap", T_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("sub_ovf",  T_SUB, 32'h8000_0000, 32'h0000_0001, 0);
    run_op("sub_borrow", T_SUB, 32'h0000_0003, 32'h0000_0005, 0);
    run_op("add_ovf",  T_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("mul_hi",   T_MUL, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("div",      T_DIV, 32'd100, 32'd7, 0);
    run_op("div0",     T_DIV, 32'd5, 32'd0, 0);
    run_op("not",      T_NOT, 32'h0F0F_1234, 32'h0, 0);
    run_op("and",      T_AND, 32'hF0F0_FFFF, 32'h0FF0_00F0, 0);
    run_op("or",       T_OR,  32'h0000_0000, 32'h0000_0000, 0);
    run_op("xor_hold", T_XOR, 32'hDEAD_BEEF, 32'hFFFF_0000, 5);
    run_op("mul_max",  T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_small", T_DIV, 32'd3, 32'hFFFF_FFFF, 2);

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? W'($urandom_range(1, 255)) : $urandom;
      run_op("rand", 3'($urandom_range(0, 7)), ra, rb, i % 2);
    end

    // Abort a multiply with reset on its tenth edge.
    A = 32'h0001_0000; B = 32'h0001_0000; Operation = T_MUL; InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    chk("abort_calc_inready", InReady, 0);
    repeat (8) @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    @(posedge Clock); #1;
    check_reset("abort");
    Reset_n = 1'b1;
    run_op("post_reset_add", T_ADD, 32'd2, 32'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be legal for any value 4..64.
REQ-002 Clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset_n  input  1  reset, synchronous and active-low.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 Operation  input  3  opcode: 000 NOT, 001 AND, 010 OR, 011 ADD, 100 SUB, 101 MUL, 110 DIV, 111 XOR.
REQ-007 InValid  input  1  operands/opcode valid.
REQ-008 InReady  output  1  block can accept a new operation.
REQ-009 Output  output  WIDTH  result (low product, quotient).
REQ-010 OutputHi  output  WIDTH  high product (MUL), remainder (DIV), else 0.
REQ-011 Zero, Carry, Overflow, DivByZero  output  1 each  status flags.
REQ-012 OutValid  output  1  result and flags valid.
REQ-013 OutReady  input  1  consumer accepts the result.

Function
REQ-014 The block SHALL use states IDLE, CALC, DONE; InReady = 1 only in IDLE; OutValid = 1 only in DONE.
REQ-015 Accept SHALL occur on an edge with InValid=1 and state IDLE; A, B, Operation SHALL be latched then, and later input changes SHALL be ignored.
REQ-016 NOT/AND/OR/XOR/ADD/SUB, and DIV with B=0, SHALL go IDLE->DONE on the accepting edge (latency 1).
REQ-017 MUL/DIV with B!=0 SHALL go IDLE->CALC, perform one iteration per cycle for WIDTH cycles, then enter DONE; OutValid SHALL rise WIDTH+1 edges after accept.
REQ-018 NOT SHALL be bitwise ~A; AND/OR/XOR bitwise; Carry=Overflow=0 for logic ops.
REQ-019 ADD: Output = (A+B) mod 2^WIDTH; Carry = carry-out; Overflow = signed two's-complement overflow.
REQ-020 SUB: Output = (A-B) mod 2^WIDTH; Carry = borrow (A<B unsigned); Overflow = signed overflow.
REQ-021 MUL: unsigned shift-add; {OutputHi,Output} = full 2*WIDTH product; Overflow = (OutputHi!=0); Carry=0.
REQ-022 DIV: unsigned restoring; Output = quotient, OutputHi = remainder.
REQ-023 DIV with B=0: Output = all ones, OutputHi = A, DivByZero = 1; otherwise DivByZero = 0.
REQ-024 Zero = (Output==0) for every opcode.
REQ-025 In DONE, all outputs SHALL hold stable until an edge with OutReady=1, which SHALL move to IDLE; no new accept on that same edge.
REQ-026 Outputs other than OutValid/InReady are don't-care outside DONE but SHALL NOT glitch while in DONE.

Reset
REQ-027 Reset_n=0 on an edge SHALL force IDLE, and OutValid=0, InReady=1, Output=OutputHi=0, and all flags 0, from any state, aborting any CALC in progress.
REQ-028 The first edge with Reset_n=1 SHALL be able to accept an operation.

Structure
REQ-029 Opcode constants and the state encoding SHALL live in shared package alu_pkg.
REQ-030 Iterative multiply/divide datapath (accumulator, shift registers, iteration counter of ceil(log2(WIDTH+1)) bits) SHALL be sub-module mul_div_iter; seq_alu holds the FSM, handshake, and single-cycle ops.

Verification (WIDTH=32)
REQ-031 ADD 0xFFFFFFFF+0x00000001 -> Output 0, Zero 1, Carry 1, Overflow 0, OutValid on the edge after accept.
REQ-032 SUB 0x80000000-0x00000001 -> Output 0x7FFFFFFF, Overflow 1, Carry 0.
REQ-033 MUL 0x00010000*0x00010000 -> Output 0, OutputHi 1, Overflow 1, Zero 1; OutValid exactly 33 edges after accept; InReady 0 throughout.
REQ-034 DIV 100/7 -> Output 14, OutputHi 2 after 33 edges; DIV 5/0 -> Output 0xFFFFFFFF, OutputHi 5, DivByZero 1, latency 1.
REQ-035 Hold OutReady=0 for 5 cycles in DONE while changing A/B -> outputs unchanged, InReady 0; then OutReady=1 -> IDLE next edge.
REQ-036 Reset_n=0 at edge 10 of a MUL -> after that edge OutValid 0, InReady 1, outputs 0; new ADD 2+3 then returns 5.
